mgt_reset_sequencer: RTL



---
 rtl/mgt_reset_sequencer_if.sv | 31 +++
 rtl/mgt_reset_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mgt_reset_sequencer_if.sv
// GTX reset controls and status between the
// reset sequencer and the transceiver.
interface mgt_reset_sequencer_if;
  logic cplllock;
  logic txresetdone;
  logic rxresetdone;
  logic cpllreset;
  logic gttxreset;
  logic gtrxreset;
  logic softreset;

  modport master (
    input  cplllock,
    input  txresetdone,
    input  rxresetdone,
    output cpllreset,
    output gttxreset,
    output gtrxreset,
    output softreset
  );

  modport slave (
    output cplllock,
    output txresetdone,
    output rxresetdone,
    input  cpllreset,
    input  gttxreset,
    input  gtrxreset,
    input  softreset
  );
endinterface

// File: rtl/mgt_reset_sequencer.sv
// Autonomous CPLL/TX/RX/soft reset sequencing for
// the event-fanout GTX, with timeouts and retries.
module mgt_reset_sequencer #(
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int DONE_TIMEOUT_CYCLES = 125000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       sysClk,
  input  logic       sysReset_n,
  input  logic       start,
  mgt_reset_sequencer_if.master mgt,
  output logic       mgtReady,
  output logic       busy,
  output logic       fault,
  output logic [3:0] retryCount,
  output logic [7:0] relockCount,
  output logic [2:0] state
);

  localparam int MaxPL =
    (RESET_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
    RESET_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MaxAll =
    (MaxPL > DONE_TIMEOUT_CYCLES) ?
    MaxPL : DONE_TIMEOUT_CYCLES;
  localparam int TW = $clog2(MaxAll + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CPLL_RST  = 3'd1,
    CPLL_WAIT = 3'd2,
    SOFT_RST  = 3'd3,
    DONE_WAIT = 3'd4,
    READY     = 3'd5,
    FAULT     = 3'd6
  } st_t;

  st_t           st;
  st_t           failSt;
  logic [TW-1:0] tmr;
  logic [6:0]    ctl;
  logic [1:0]    lockSync;
  logic [1:0]    txSync;
  logic [1:0]    rxSync;
  logic          lockS;
  logic          doneS;
  logic          retryOk;

  assign lockS   = lockSync[1];
  assign doneS   = txSync[1] & rxSync[1];
  assign retryOk = retryCount < 4'(MAX_RETRIES);
  assign failSt  = retryOk ? CPLL_RST : FAULT;
  assign state   = st;

  // ctl = {cpll, gttx, gtrx, soft, ready, busy, fault}
  assign {mgt.cpllreset, mgt.gttxreset,
          mgt.gtrxreset, mgt.softreset,
          mgtReady, busy, fault} = ctl;

  function automatic logic [6:0] ctlOf(st_t s);
    unique case (s)
      CPLL_RST:  return 7'b1110010;
      CPLL_WAIT: return 7'b0110010;
      SOFT_RST:  return 7'b0001010;
      DONE_WAIT: return 7'b0000010;
      READY:     return 7'b0000100;
      FAULT:     return 7'b1000001;
      default:   return 7'b0000000;
    endcase
  endfunction

  // Timer holds cycles remaining after the current one.
  function automatic logic [TW-1:0] tmrOf(st_t s);
    unique case (s)
      CPLL_RST:  return TW'(RESET_PULSE_CYCLES - 1);
      CPLL_WAIT: return TW'(LOCK_TIMEOUT_CYCLES - 1);
      SOFT_RST:  return TW'(RESET_PULSE_CYCLES - 1);
      DONE_WAIT: return TW'(DONE_TIMEOUT_CYCLES - 1);
      default:   return '0;
    endcase
  endfunction

  always_ff @(posedge sysClk) begin
    if (!sysReset_n) begin
      st          <= IDLE;
      tmr         <= '0;
      ctl         <= '0;
      retryCount  <= '0;
      relockCount <= '0;
      lockSync    <= '0;
      txSync      <= '0;
      rxSync      <= '0;
    end else begin
      lockSync <= {lockSync[0], mgt.cplllock};
      txSync   <= {txSync[0], mgt.txresetdone};
      rxSync   <= {rxSync[0], mgt.rxresetdone};
      unique case (st)
        IDLE, FAULT: begin
          if (start) begin
            st         <= CPLL_RST;
            ctl        <= ctlOf(CPLL_RST);
            tmr        <= tmrOf(CPLL_RST);
            retryCount <= '0;
          end
        end
        CPLL_RST: begin
          if (tmr == '0) begin
            st  <= CPLL_WAIT;
            ctl <= ctlOf(CPLL_WAIT);
            tmr <= tmrOf(CPLL_WAIT);
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        CPLL_WAIT: begin
          if (lockS) begin
            st  <= SOFT_RST;
            ctl <= ctlOf(SOFT_RST);
            tmr <= tmrOf(SOFT_RST);
          end else if (tmr == '0) begin
            st  <= failSt;
            ctl <= ctlOf(failSt);
            tmr <= tmrOf(failSt);
            if (retryOk) retryCount <= retryCount + 4'd1;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        SOFT_RST: begin
          if (tmr == '0) begin
            st  <= DONE_WAIT;
            ctl <= ctlOf(DONE_WAIT);
            tmr <= tmrOf(DONE_WAIT);
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        DONE_WAIT: begin
          if (doneS) begin
            st  <= READY;
            ctl <= ctlOf(READY);
            tmr <= tmrOf(READY);
          end else if (!lockS || tmr == '0) begin
            st  <= failSt;
            ctl <= ctlOf(failSt);
            tmr <= tmrOf(failSt);
            if (retryOk) retryCount <= retryCount + 4'd1;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        READY: begin
          if (!lockS && relockCount != 8'hFF)
            relockCount <= relockCount + 8'd1;
          if (start || !lockS) begin
            st         <= CPLL_RST;
            ctl        <= ctlOf(CPLL_RST);
            tmr        <= tmrOf(CPLL_RST);
            retryCount <= '0;
          end
        end
        default: begin
          st  <= IDLE;
          ctl <= '0;
          tmr <= '0;
        end
      endcase
    end
  end

endmodule
